// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: passes ALU results straight through and stalls upstream while a
// memory access waits for its ack. Optional forwarding outputs are enabled by MEM_WB_FWD_EN.
module mem_wb_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        In_Valid,
  input  logic        In_RegWrite,
  input  logic        In_MemRead,
  input  logic        In_MemWrite,
  input  logic [1:0]  In_MemToReg,
  input  logic [2:0]  In_WriteReg,
  input  logic [15:0] In_ALU_Result,
  input  logic [15:0] In_Store_Data,
  input  logic [15:0] In_PC_Adder,
  output logic        Stall_Out,
  output logic        Mem_Req,
  output logic        Mem_We,
  output logic [15:0] Mem_Addr,
  output logic [15:0] Mem_WData,
  input  logic        Mem_Ack,
  input  logic [15:0] Mem_RData,
  output logic        WB_Valid,
  output logic        WB_RegWrite,
  output logic [1:0]  WB_MemToReg,
  output logic [2:0]  WB_WriteReg,
  output logic [15:0] WB_ALU_Result,
  output logic [15:0] WB_Read_Data,
  output logic [15:0] WB_PC_Adder
`ifdef MEM_WB_FWD_EN
  ,
  output logic        Fwd_Valid,
  output logic [2:0]  Fwd_WriteReg,
  output logic [15:0] Fwd_Data
`endif
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]  state_q, state_d;

  logic        holdRegWrite_q, holdRegWrite_d;
  logic        holdWe_q, holdWe_d;
  logic [1:0]  holdMemToReg_q, holdMemToReg_d;
  logic [2:0]  holdWriteReg_q, holdWriteReg_d;
  logic [15:0] holdAlu_q, holdAlu_d;
  logic [15:0] holdStore_q, holdStore_d;
  logic [15:0] holdPc_q, holdPc_d;

  logic        wbValid_q, wbValid_d;
  logic        wbRegWrite_q, wbRegWrite_d;
  logic [1:0]  wbMemToReg_q, wbMemToReg_d;
  logic [2:0]  wbWriteReg_q, wbWriteReg_d;
  logic [15:0] wbAlu_q, wbAlu_d;
  logic [15:0] wbRdata_q, wbRdata_d;
  logic [15:0] wbPc_q, wbPc_d;

  logic inAccess;
  assign inAccess = (state_q == ACCESS);

  always_comb begin
    state_d        = state_q;
    holdRegWrite_d = holdRegWrite_q;
    holdWe_d       = holdWe_q;
    holdMemToReg_d = holdMemToReg_q;
    holdWriteReg_d = holdWriteReg_q;
    holdAlu_d      = holdAlu_q;
    holdStore_d    = holdStore_q;
    holdPc_d       = holdPc_q;
    wbValid_d      = 1'b0;
    wbRegWrite_d   = 1'b0;
    wbMemToReg_d   = wbMemToReg_q;
    wbWriteReg_d   = wbWriteReg_q;
    wbAlu_d        = wbAlu_q;
    wbRdata_d      = wbRdata_q;
    wbPc_d         = wbPc_q;

    if (inAccess) begin
      // Upstream inputs are ignored here; only the ack moves the stage on.
      if (Mem_Ack) begin
        state_d      = IDLE;
        wbValid_d    = 1'b1;
        wbRegWrite_d = holdRegWrite_q;
        wbMemToReg_d = holdMemToReg_q;
        wbWriteReg_d = holdWriteReg_q;
        wbAlu_d      = holdAlu_q;
        wbRdata_d    = holdWe_q ? 16'h0000 : Mem_RData;
        wbPc_d       = holdPc_q;
      end
    end else if (In_Valid) begin
      if (In_MemRead || In_MemWrite) begin
        state_d        = ACCESS;
        holdRegWrite_d = In_RegWrite;
        holdWe_d       = In_MemWrite;
        holdMemToReg_d = In_MemToReg;
        holdWriteReg_d = In_WriteReg;
        holdAlu_d      = In_ALU_Result;
        holdStore_d    = In_Store_Data;
        holdPc_d       = In_PC_Adder;
      end else begin
        wbValid_d    = 1'b1;
        wbRegWrite_d = In_RegWrite;
        wbMemToReg_d = In_MemToReg;
        wbWriteReg_d = In_WriteReg;
        wbAlu_d      = In_ALU_Result;
        wbRdata_d    = 16'h0000;
        wbPc_d       = In_PC_Adder;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      holdRegWrite_q <= 1'b0;
      holdWe_q       <= 1'b0;
      holdMemToReg_q <= 2'b00;
      holdWriteReg_q <= 3'b000;
      holdAlu_q      <= 16'h0000;
      holdStore_q    <= 16'h0000;
      holdPc_q       <= 16'h0000;
      wbValid_q      <= 1'b0;
      wbRegWrite_q   <= 1'b0;
      wbMemToReg_q   <= 2'b00;
      wbWriteReg_q   <= 3'b000;
      wbAlu_q        <= 16'h0000;
      wbRdata_q      <= 16'h0000;
      wbPc_q         <= 16'h0000;
    end else begin
      state_q        <= state_d;
      holdRegWrite_q <= holdRegWrite_d;
      holdWe_q       <= holdWe_d;
      holdMemToReg_q <= holdMemToReg_d;
      holdWriteReg_q <= holdWriteReg_d;
      holdAlu_q      <= holdAlu_d;
      holdStore_q    <= holdStore_d;
      holdPc_q       <= holdPc_d;
      wbValid_q      <= wbValid_d;
      wbRegWrite_q   <= wbRegWrite_d;
      wbMemToReg_q   <= wbMemToReg_d;
      wbWriteReg_q   <= wbWriteReg_d;
      wbAlu_q        <= wbAlu_d;
      wbRdata_q      <= wbRdata_d;
      wbPc_q         <= wbPc_d;
    end
  end

  // Hold registers keep the last op after completion, so the port is gated to zero in IDLE.
  assign Stall_Out = inAccess;
  assign Mem_Req   = inAccess;
  assign Mem_We    = inAccess & holdWe_q;
  assign Mem_Addr  = inAccess ? holdAlu_q : 16'h0000;
  assign Mem_WData = inAccess ? holdStore_q : 16'h0000;

  assign WB_Valid      = wbValid_q;
  assign WB_RegWrite   = wbRegWrite_q;
  assign WB_MemToReg   = wbMemToReg_q;
  assign WB_WriteReg   = wbWriteReg_q;
  assign WB_ALU_Result = wbAlu_q;
  assign WB_Read_Data  = wbRdata_q;
  assign WB_PC_Adder   = wbPc_q;

`ifdef MEM_WB_FWD_EN
  assign Fwd_Valid    = wbValid_q & wbRegWrite_q;
  assign Fwd_WriteReg = wbWriteReg_q;
  always_comb begin
    case (wbMemToReg_q)
      2'b01:   Fwd_Data = wbRdata_q;
      2'b10:   Fwd_Data = wbPc_q;
      default: Fwd_Data = wbAlu_q;
    endcase
  end
`endif

endmodule
